// File: rtl/uart_frame_rx.sv
// uart_frame_rx: receives SOF(0xA5) / LEN / payload / XOR-CHK frames into a hold buffer.
// Optional inter-byte timeout is compiled in when FRAME_TIMEOUT_EN is defined.
module uart_frame_rx #(
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 25000,
  localparam int AW            = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dataValid,
  input  logic [7:0]    rxData,
  output logic          frameValid,
  output logic [7:0]    frameLen,
  input  logic [AW-1:0] rdAddr,
  output logic [7:0]    rdData,
  input  logic          frameAck,
  output logic          frameError,
  output logic [2:0]    errCode
);

  localparam logic [7:0] SOF         = 8'hA5;
  localparam logic [2:0] ERR_BAD_LEN = 3'd1;
  localparam logic [2:0] ERR_BAD_CHK = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  if ((MAX_LEN < 1) || (MAX_LEN > 255) || (TIMEOUT_CYCLES < 1)) begin : gParamCheck
    $error("uart_frame_rx: MAX_LEN must be 1..255 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_HOLD
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] chk_q, chk_d;
  logic       frameValid_q, frameValid_d;
  logic [7:0] frameLen_q, frameLen_d;
  logic       frameError_q, frameError_d;
  logic [2:0] errCode_q, errCode_d;
  logic [7:0] rdData_q;
  logic       wrEn;

  // Payload storage is deliberately not reset; only written while collecting payload.
  logic [7:0] mem [0:(1<<AW)-1];

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    chk_d        = chk_q;
    frameValid_d = frameValid_q;
    frameLen_d   = frameLen_q;
    frameError_d = 1'b0;
    errCode_d    = errCode_q;
    wrEn         = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (dataValid && (rxData == SOF)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (dataValid) begin
          if ((rxData == 8'd0) || (int'(rxData) > MAX_LEN)) begin
            frameError_d = 1'b1;
            errCode_d    = ERR_BAD_LEN;
            state_d      = ST_HUNT;
          end else begin
            len_d   = rxData;
            idx_d   = 8'd0;
            chk_d   = rxData;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (dataValid) begin
          wrEn  = 1'b1;
          chk_d = chk_q ^ rxData;
          idx_d = idx_q + 8'd1;
          if ((idx_q + 8'd1) == len_q) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (dataValid) begin
          if (rxData == chk_q) begin
            frameValid_d = 1'b1;
            frameLen_d   = len_q;
            state_d      = ST_HOLD;
          end else begin
            frameError_d = 1'b1;
            errCode_d    = ERR_BAD_CHK;
            state_d      = ST_HUNT;
          end
        end
      end
      ST_HOLD: begin
        // A byte arriving with the release is the first byte of the next hunt.
        if (frameAck) begin
          frameValid_d = 1'b0;
          state_d      = (dataValid && (rxData == SOF)) ? ST_LEN : ST_HUNT;
        end else if (dataValid) begin
          frameError_d = 1'b1;
          errCode_d    = ERR_OVERRUN;
        end
      end
      default: state_d = ST_HUNT;
    endcase

`ifdef FRAME_TIMEOUT_EN
    if (((state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK)) &&
        !dataValid && (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
      frameError_d = 1'b1;
      errCode_d    = ERR_TIMEOUT;
      state_d      = ST_HUNT;
    end
    if (dataValid ||
        !((state_d == ST_LEN) || (state_d == ST_PAYLOAD) || (state_d == ST_CHECK)))
      tmo_d = '0;
    else
      tmo_d = tmo_q + TW'(1);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_HUNT;
      len_q        <= 8'd0;
      idx_q        <= 8'd0;
      chk_q        <= 8'd0;
      frameValid_q <= 1'b0;
      frameLen_q   <= 8'd0;
      frameError_q <= 1'b0;
      errCode_q    <= 3'd0;
      rdData_q     <= 8'd0;
`ifdef FRAME_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      chk_q        <= chk_d;
      frameValid_q <= frameValid_d;
      frameLen_q   <= frameLen_d;
      frameError_q <= frameError_d;
      errCode_q    <= errCode_d;
      rdData_q     <= mem[rdAddr];
`ifdef FRAME_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[idx_q[AW-1:0]] <= rxData;
  end

  assign frameValid = frameValid_q;
  assign frameLen   = frameLen_q;
  assign frameError = frameError_q;
  assign errCode    = errCode_q;
  assign rdData     = rdData_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: vector table plus hand sequences for
// max-length, reset mid-frame and timeout behaviour (FRAME_TIMEOUT_EN aware).
module tb_uart_frame_rx;

  logic       clk;
  logic       reset;
  logic       dataValid;
  logic [7:0] rxData;
  logic       frameValid;
  logic [7:0] frameLen;
  logic [5:0] rdAddr;
  logic [7:0] rdData;
  logic       frameAck;
  logic       frameError;
  logic [2:0] errCode;

  int nVec = 0;
  int nMis = 0;

  uart_frame_rx #(.MAX_LEN(64), .TIMEOUT_CYCLES(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .dataValid  (dataValid),
    .rxData     (rxData),
    .frameValid (frameValid),
    .frameLen   (frameLen),
    .rdAddr     (rdAddr),
    .rdData     (rdData),
    .frameAck   (frameAck),
    .frameError (frameError),
    .errCode    (errCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [7:0] data;
    logic       ack;
    logic [5:0] addr;
    logic       eFv;
    logic       chkLen;
    logic [7:0] eLen;
    logic       eErr;
    logic [2:0] eCode;
    logic       chkRd;
    logic [7:0] eRd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic dv, input logic [7:0] data, input logic ack,
                              input logic [5:0] addr, input logic eFv, input logic [7:0] eLen,
                              input logic eErr, input logic [2:0] eCode,
                              input logic chkRd, input logic [7:0] eRd);
    vec_t v;
    v.dv = dv; v.data = data; v.ack = ack; v.addr = addr;
    v.eFv = eFv; v.chkLen = eFv; v.eLen = eLen;
    v.eErr = eErr; v.eCode = eCode; v.chkRd = chkRd; v.eRd = eRd;
    return v;
  endfunction

  function automatic vec_t vByte(input logic [7:0] d, input logic eFv, input logic [7:0] eLen,
                                 input logic eErr, input logic [2:0] eCode);
    return mk(1'b1, d, 1'b0, 6'd0, eFv, eLen, eErr, eCode, 1'b0, 8'd0);
  endfunction

  function automatic vec_t vRead(input logic [5:0] a, input logic eFv, input logic [7:0] eLen,
                                 input logic eErr, input logic [2:0] eCode, input logic [7:0] eRd);
    return mk(1'b0, 8'd0, 1'b0, a, eFv, eLen, eErr, eCode, 1'b1, eRd);
  endfunction

  function automatic vec_t vAck(input logic dv, input logic [7:0] d,
                                input logic [2:0] eCode);
    return mk(dv, d, 1'b1, 6'd0, 1'b0, 8'd0, 1'b0, eCode, 1'b0, 8'd0);
  endfunction

  task automatic applyStimulus(input logic dv, input logic [7:0] d, input logic ack,
                               input logic [5:0] a);
    dataValid = dv;
    rxData    = d;
    frameAck  = ack;
    rdAddr    = a;
    @(posedge clk);
    #1;
    dataValid = 1'b0;
    frameAck  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic eFv, input logic chkLen,
                             input logic [7:0] eLen, input logic eErr, input logic [2:0] eCode,
                             input logic chkRd, input logic [7:0] eRd);
    nVec++;
    if ((frameValid !== eFv) || (chkLen && (frameLen !== eLen)) ||
        (frameError !== eErr) || (errCode !== eCode) || (chkRd && (rdData !== eRd))) begin
      nMis++;
      $display("[TB] FAIL %s: got fv=%b len=%0d err=%b code=%0d rd=%h, expected fv=%b len=%0d(chk %b) err=%b code=%0d rd=%h(chk %b)",
               name, frameValid, frameLen, frameError, errCode, rdData,
               eFv, eLen, chkLen, eErr, eCode, eRd, chkRd);
    end
  endtask

  task automatic sendByte(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, 6'd0);
  endtask

  initial begin
    logic [7:0] data64 [64];
    logic [7:0] chk;
    int         n;
    logic       seen;
    int         seenAt;

    reset     = 1'b0;
    dataValid = 1'b0;
    rxData    = 8'd0;
    frameAck  = 1'b0;
    rdAddr    = 6'd0;

    // Good frame, readback, release, ack ignored outside HOLD
    vecs.push_back(vByte(8'hA5, 0, 0, 0, 0));
    vecs.push_back(vByte(8'h03, 0, 0, 0, 0));
    vecs.push_back(vByte(8'h11, 0, 0, 0, 0));
    vecs.push_back(vByte(8'h22, 0, 0, 0, 0));
    vecs.push_back(vByte(8'h33, 0, 0, 0, 0));
    vecs.push_back(vByte(8'h03, 1, 3, 0, 0));
    vecs.push_back(vRead(6'd0, 1, 3, 0, 0, 8'h11));
    vecs.push_back(vRead(6'd1, 1, 3, 0, 0, 8'h22));
    vecs.push_back(vRead(6'd2, 1, 3, 0, 0, 8'h33));
    vecs.push_back(vAck(1'b0, 8'h00, 0));
    vecs.push_back(vAck(1'b0, 8'h00, 0));
    // Bad checksum
    vecs.push_back(vByte(8'hA5, 0, 0, 0, 0));
    vecs.push_back(vByte(8'h03, 0, 0, 0, 0));
    vecs.push_back(vByte(8'h11, 0, 0, 0, 0));
    vecs.push_back(vByte(8'h22, 0, 0, 0, 0));
    vecs.push_back(vByte(8'h33, 0, 0, 0, 0));
    vecs.push_back(vByte(8'h04, 0, 0, 1, 2));
    vecs.push_back(vRead(6'd0, 0, 0, 0, 2, 8'h11));
    // Bad lengths 0 and MAX_LEN+1, stray byte in HUNT
    vecs.push_back(vByte(8'hA5, 0, 0, 0, 2));
    vecs.push_back(vByte(8'h00, 0, 0, 1, 1));
    vecs.push_back(vRead(6'd0, 0, 0, 0, 1, 8'h11));
    vecs.push_back(vByte(8'hA5, 0, 0, 0, 1));
    vecs.push_back(vByte(8'h41, 0, 0, 1, 1));
    vecs.push_back(vRead(6'd0, 0, 0, 0, 1, 8'h11));
    vecs.push_back(vByte(8'h5A, 0, 0, 0, 1));
    // One-byte frame, then overrun while held
    vecs.push_back(vByte(8'hA5, 0, 0, 0, 1));
    vecs.push_back(vByte(8'h01, 0, 0, 0, 1));
    vecs.push_back(vByte(8'h7E, 0, 0, 0, 1));
    vecs.push_back(vByte(8'h7F, 1, 1, 0, 1));
    vecs.push_back(mk(1'b1, 8'h5A, 1'b0, 6'd0, 1, 1, 1, 4, 1'b1, 8'h7E));
    vecs.push_back(vRead(6'd0, 1, 1, 0, 4, 8'h7E));
    vecs.push_back(vByte(8'hA5, 1, 1, 1, 4));
    vecs.push_back(vRead(6'd0, 1, 1, 0, 4, 8'h7E));
    // Ack coincident with SOF starts the next frame
    vecs.push_back(vAck(1'b1, 8'hA5, 4));
    vecs.push_back(vByte(8'h02, 0, 0, 0, 4));
    vecs.push_back(vByte(8'hAA, 0, 0, 0, 4));
    vecs.push_back(vByte(8'hBB, 0, 0, 0, 4));
    vecs.push_back(vByte(8'h13, 1, 2, 0, 4));
    vecs.push_back(vRead(6'd1, 1, 2, 0, 4, 8'hBB));
    vecs.push_back(vAck(1'b0, 8'h00, 4));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetState", 0, 1, 8'd0, 0, 3'd0, 1, 8'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dv, vecs[i].data, vecs[i].ack, vecs[i].addr);
      checkOutput($sformatf("vec%0d", i), vecs[i].eFv, vecs[i].chkLen, vecs[i].eLen,
                  vecs[i].eErr, vecs[i].eCode, vecs[i].chkRd, vecs[i].eRd);
    end

    // Maximum length frame
    sendByte(8'hA5);
    sendByte(8'h40);
    chk = 8'h40;
    for (int i = 0; i < 64; i++) begin
      data64[i] = 8'((i * 3) + 1);
      chk ^= data64[i];
      sendByte(data64[i]);
    end
    checkOutput("len64Partial", 0, 0, 8'd0, 0, 3'd4, 0, 8'd0);
    sendByte(chk);
    checkOutput("len64Accept", 1, 1, 8'd64, 0, 3'd4, 0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 6'd63);
    checkOutput("len64Rd63", 1, 1, 8'd64, 0, 3'd4, 1, data64[63]);
    applyStimulus(1'b0, 8'd0, 1'b0, 6'd0);
    checkOutput("len64Rd0", 1, 1, 8'd64, 0, 3'd4, 1, data64[0]);
    applyStimulus(1'b0, 8'd0, 1'b1, 6'd0);
    checkOutput("len64Ack", 0, 0, 8'd0, 0, 3'd4, 0, 8'd0);

    // Reset mid-payload, then a clean frame
    sendByte(8'hA5);
    sendByte(8'h02);
    sendByte(8'h11);
    reset = 1'b0;
    #2;
    checkOutput("resetMid", 0, 1, 8'd0, 0, 3'd0, 1, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sendByte(8'hA5);
    checkOutput("postResetSof", 0, 0, 8'd0, 0, 3'd0, 0, 8'd0);
    sendByte(8'h02);
    sendByte(8'h44);
    sendByte(8'h55);
    sendByte(8'h02 ^ 8'h44 ^ 8'h55);
    checkOutput("postResetFrame", 1, 1, 8'd2, 0, 3'd0, 0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 6'd0);
    checkOutput("postResetRd0", 1, 1, 8'd2, 0, 3'd0, 1, 8'h44);
    applyStimulus(1'b0, 8'd0, 1'b0, 6'd1);
    checkOutput("postResetRd1", 1, 1, 8'd2, 0, 3'd0, 1, 8'h55);
    applyStimulus(1'b0, 8'd0, 1'b1, 6'd0);

    // Idle gap inside a partial frame
    sendByte(8'hA5);
    sendByte(8'h02);
    sendByte(8'h11);
    seen   = 1'b0;
    seenAt = 0;
    n      = 0;
    while (!seen && (n < 130)) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 6'd0);
      n++;
      if (frameError) begin
        seen   = 1'b1;
        seenAt = n;
      end
    end
`ifdef FRAME_TIMEOUT_EN
    nVec++;
    if (!seen || (seenAt != 100) || (errCode !== 3'd3)) begin
      nMis++;
      $display("[TB] FAIL timeoutPulse: got seen=%b at=%0d code=%0d, expected seen=1 at=100 code=3",
               seen, seenAt, errCode);
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 6'd0);
    checkOutput("timeoutPulseWidth", 0, 0, 8'd0, 0, 3'd3, 0, 8'd0);
    sendByte(8'h22);
    sendByte(8'h02 ^ 8'h11 ^ 8'h22);
    checkOutput("timeoutDiscard", 0, 0, 8'd0, 0, 3'd3, 0, 8'd0);
`else
    nVec++;
    if (seen) begin
      nMis++;
      $display("[TB] FAIL noTimeout: got error pulse at idle cycle %0d code=%0d, expected none",
               seenAt, errCode);
    end
    sendByte(8'h22);
    sendByte(8'h02 ^ 8'h11 ^ 8'h22);
    checkOutput("lateComplete", 1, 1, 8'd2, 0, 3'd0, 0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 6'd0);
    checkOutput("lateRd0", 1, 1, 8'd2, 0, 3'd0, 1, 8'h11);
    applyStimulus(1'b0, 8'd0, 1'b0, 6'd1);
    checkOutput("lateRd1", 1, 1, 8'd2, 0, 3'd0, 1, 8'h22);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
